// File: rtl/fir_pkg.sv
// Shared FIR definitions: default core geometry and the tap loader state encoding.
package fir_pkg;

   localparam int FIR_DATA_W   = 32;
   localparam int FIR_IDX_W    = 4;
   localparam int FIR_NUM_TAPS = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HOLD,
      GAP,
      DONE
   } tap_ld_state_t;

endpackage

// File: rtl/fir_tap_loader.sv
// Replays a streamed burst of NUM_TAPS coefficients as tap write strobes into the
// FIR core, holding the filter disabled for the duration of the load.
module fir_tap_loader
   import fir_pkg::*;
#(
   parameter int DATA_W      = FIR_DATA_W,
   parameter int IDX_W       = FIR_IDX_W,
   parameter int NUM_TAPS    = FIR_NUM_TAPS,
   parameter int HOLD_CYCLES = 2,
   parameter int GAP_CYCLES  = 1
) (
   input  logic              CLK,
   input  logic              sreset,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              tap_Transfer,
   output logic [IDX_W-1:0]  tap_Index,
   output logic [DATA_W-1:0] tap_Value,
   output logic              en_FIR,
   output logic              busy,
   output logic              done
);

   localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

   tap_ld_state_t     state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              loading_d;

   // One down-counter is shared by HOLD and GAP; it is reloaded on each entry.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               idx_d   = '0;
            end
         end
         LOAD: begin
            if (s_valid && s_ready) begin
               state_d = HOLD;
               data_d  = s_data;
               cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = CNT_W'(GAP_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               state_d = LOAD;
               idx_d   = idx_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Abort beats everything, including a start seen in the same IDLE cycle.
      if (abort) state_d = IDLE;
      loading_d = (state_d == LOAD) || (state_d == HOLD) || (state_d == GAP);
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge CLK) begin
      if (sreset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         data_q       <= '0;
         tap_Transfer <= 1'b0;
         tap_Index    <= '0;
         tap_Value    <= '0;
         en_FIR       <= 1'b1;
         s_ready      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         tap_Transfer <= (state_d == HOLD);
         tap_Index    <= (state_d == HOLD) ? idx_d : '0;
         tap_Value    <= (state_d == HOLD) ? data_d : '0;
         en_FIR       <= !loading_d;
         s_ready      <= (state_d == LOAD);
         busy         <= loading_d;
         done         <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader: full loads, backpressure, abort, start-while-busy, reset mid-load.
module tb_fir_tap_loader;

   logic        CLK = 1'b0;
   logic        sreset, start, abort, s_valid, s_ready;
   logic [31:0] s_data;
   logic        tap_Transfer;
   logic [3:0]  tap_Index;
   logic [31:0] tap_Value;
   logic        en_FIR, busy, done;

   int n_cmp = 0;
   int n_err = 0;

   fir_tap_loader dut (
      .CLK          (CLK),
      .sreset       (sreset),
      .start        (start),
      .abort        (abort),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .tap_Transfer (tap_Transfer),
      .tap_Index    (tap_Index),
      .tap_Value    (tap_Value),
      .en_FIR       (en_FIR),
      .busy         (busy),
      .done         (done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_tr"},   32'(tap_Transfer), 32'd0);
      chk({tag, "_idx"},  32'(tap_Index),    32'd0);
      chk({tag, "_val"},  tap_Value,         32'd0);
      chk({tag, "_en"},   32'(en_FIR),       32'd1);
      chk({tag, "_rdy"},  32'(s_ready),      32'd0);
      chk({tag, "_busy"}, 32'(busy),         32'd0);
      chk({tag, "_done"}, 32'(done),         32'd0);
   endtask

   // Unstalled load of all-ones; each tap takes 4 cycles: LOAD, HOLD, HOLD, GAP.
   task automatic full_load(input int poke);
      logic exp_tr;
      s_valid = 1'b1;
      s_data  = 32'hFFFF_FFFF;
      start   = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c <= 65; c++) begin
         exp_tr = (c < 64) && ((c % 4 == 1) || (c % 4 == 2));
         chk("fl_tr",   32'(tap_Transfer), 32'(exp_tr));
         chk("fl_idx",  32'(tap_Index),    exp_tr ? 32'(c / 4) : 32'd0);
         chk("fl_val",  tap_Value,         exp_tr ? 32'hFFFF_FFFF : 32'd0);
         chk("fl_rdy",  32'(s_ready),      32'((c < 64) && (c % 4 == 0)));
         chk("fl_busy", 32'(busy),         32'(c < 64));
         chk("fl_en",   32'(en_FIR),       32'(c >= 64));
         chk("fl_done", 32'(done),         32'(c == 64));
         start = (c == poke);
         tick();
      end
      start   = 1'b0;
      s_valid = 1'b0;
   endtask

   task automatic backpressure();
      int   sent, nstb, ndone, pat;
      logic hs, prev_tr, fin;
      sent = 0; nstb = 0; ndone = 0; pat = 0; prev_tr = 1'b0; fin = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 400 && !fin; c++) begin
         s_valid = (pat % 3 == 0);
         s_data  = 32'(sent) * 32'h1111;
         pat++;
         hs = s_valid && s_ready;
         tick();
         if (hs) sent++;
         if (tap_Transfer) begin
            chk("bp_idx", 32'(tap_Index), 32'(nstb / 2));
            chk("bp_val", tap_Value, 32'(nstb / 2) * 32'h1111);
            if (!prev_tr) chk("bp_strobe_after_hs", 32'(hs), 32'd1);
            nstb++;
         end
         prev_tr = tap_Transfer;
         if (done) begin
            ndone++;
            fin = 1'b1;
         end
      end
      s_valid = 1'b0;
      chk("bp_strobes", 32'(nstb),  32'd32);
      chk("bp_sent",    32'(sent),  32'd16);
      chk("bp_done",    32'(ndone), 32'd1);
      tick();
      chk_idle("bp_end");
   endtask

   initial begin
      sreset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) tick();
      chk_idle("rst");
      sreset = 1'b0;
      tick();
      chk_idle("post_rst");

      full_load(-1);
      full_load(12);
      backpressure();

      // Abort during HOLD of tap 5 (cycle 21 after LOAD entry).
      s_valid = 1'b1; s_data = 32'hA5A5_5A5A; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (21) tick();
      chk("ab_pre_tr",  32'(tap_Transfer), 32'd1);
      chk("ab_pre_idx", 32'(tap_Index),    32'd5);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle("ab");
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ab_no_done", 32'(done), 32'd0);
         chk("ab_no_busy", 32'(busy), 32'd0);
      end
      s_data = 32'h0000_BEEF; start = 1'b1;
      tick();
      start = 1'b0;
      chk("ab_rst_rdy", 32'(s_ready), 32'd1);
      tick();
      chk("ab_rst_tr",  32'(tap_Transfer), 32'd1);
      chk("ab_rst_idx", 32'(tap_Index),    32'd0);
      chk("ab_rst_val", tap_Value,         32'h0000_BEEF);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle("ab2");

      // start and abort together in IDLE: abort wins.
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk_idle("sa");
      tick();
      chk_idle("sa2");

      // sreset during HOLD of tap 9 (cycle 37).
      s_data = 32'h1357_9BDF; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (37) tick();
      chk("sr_pre_idx", 32'(tap_Index), 32'd9);
      sreset = 1'b1;
      tick();
      sreset = 1'b0;
      chk_idle("sr");
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("sr_rdy_low", 32'(s_ready), 32'd0);
         chk("sr_en",      32'(en_FIR),  32'd1);
      end
      s_data = 32'h0000_1234; start = 1'b1;
      tick();
      start = 1'b0;
      chk("sr_new_rdy", 32'(s_ready), 32'd1);
      chk("sr_new_en",  32'(en_FIR),  32'd0);
      tick();
      chk("sr_new_idx", 32'(tap_Index), 32'd0);
      chk("sr_new_val", tap_Value,      32'h0000_1234);
      abort = 1'b1; s_valid = 1'b0;
      tick();
      abort = 1'b0;
      chk_idle("end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
